// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// FSM state encoding and the legal parameter ranges.
package seq_detect_pkg;

    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 16;
    localparam int CNT_W_MIN   = 2;
    localparam int CNT_W_MAX   = 16;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    function automatic bit in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
    import seq_detect_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    if (!in_range(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_cnt_w
        $error("sat_counter: CNT_W out of range");
    end

    // Count up on inc, hold at all-ones, zero on clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlap control and a
// saturating match counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FILL  | fewer than PAT_LEN fresh bits held; no match possible yet
//   ST_ARMED | PAT_LEN fresh bits held; every accepted bit may complete one
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int               PAT_LEN     = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_LEN-1:0] RST_PATTERN = PAT_LEN'(4'b1011),
    parameter logic             RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_valid,
    input  logic               inp_bit,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    input  logic               cnt_clear,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               hist_full
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    if (!in_range(PAT_LEN, PAT_LEN_MIN, PAT_LEN_MAX)) begin : g_bad_pat_len
        $error("seq_detect_prog: PAT_LEN out of range");
    end

    logic [PAT_LEN-1:0] pattern_q;
    logic               overlap_q;
    // Only the newest PAT_LEN-1 bits are kept; the oldest bit of a candidate
    // window is needed just for the compare and is never stored.
    logic [PAT_LEN-2:0] history_q;
    logic [PAT_LEN-1:0] window;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_nxt;
    logic [0:0]         state_q;
    logic [0:0]         state_nxt;
    logic               accept;
    logic               match;
    logic               drop_fill;

    // Candidate window and match decision for the bit on the wire this cycle.
    always_comb begin
        accept    = inp_valid & ~cfg_load;
        window    = {history_q, inp_bit};
        fill_nxt  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        match     = accept && (window == pattern_q) && (fill_nxt == FILL_FULL);
        drop_fill = match & ~overlap_q;
    end

    // FSM next state: arm once the window is full, fall back on a
    // non-overlapping match or a reconfiguration.
    always_comb begin
        state_nxt = state_q;
        if (cfg_load) begin
            state_nxt = ST_FILL;
        end else if (accept) begin
            case (state_q)
                ST_FILL:  if ((fill_nxt == FILL_FULL) && !drop_fill) state_nxt = ST_ARMED;
                ST_ARMED: if (drop_fill) state_nxt = ST_FILL;
                default:  state_nxt = ST_FILL;
            endcase
        end
    end

    // Configuration, shift history and fill tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= RST_PATTERN;
            overlap_q <= RST_OVERLAP;
            history_q <= '0;
            fill_q    <= '0;
            state_q   <= ST_FILL;
        end else begin
            state_q <= state_nxt;
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                overlap_q <= cfg_overlap;
                history_q <= '0;
                fill_q    <= '0;
            end else if (accept) begin
                history_q <= window[PAT_LEN-2:0];
                fill_q    <= drop_fill ? '0 : fill_nxt;
            end
        end
    end

    // One-cycle registered match pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_seen <= 1'b0;
        end else begin
            seq_seen <= match;
        end
    end

    assign hist_full = (state_q == ST_ARMED);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (cnt_clear),
        .count (match_count)
    );

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter PAT_LEN, default 4, SHALL set pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8, SHALL set match-counter width in bits; legal range 2..16.
REQ-003 Parameter RST_PATTERN, default 4'b1011 (PAT_LEN bits), SHALL set the pattern loaded at reset.
REQ-004 Parameter RST_OVERLAP, default 1, SHALL set the overlap mode loaded at reset.
REQ-005 clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 inp_valid  input  1  qualifies inp_bit for the current cycle.
REQ-008 inp_bit  input  1  serial data bit, sampled only when inp_valid=1.
REQ-009 cfg_load  input  1  one-cycle strobe; loads cfg_pattern and cfg_overlap.
REQ-010 cfg_pattern  input  PAT_LEN  new pattern; MSB is the first bit expected on the wire.
REQ-011 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-012 cnt_clear  input  1  one-cycle strobe; zeroes match_count.
REQ-013 seq_seen  output  1  registered one-cycle pulse per detected match.
REQ-014 match_count  output  CNT_W  saturating count of matches since reset or last clear.
REQ-015 hist_full  output  1  high when at least PAT_LEN valid bits are held since the last flush.

Function
REQ-016 On an accepted bit (inp_valid=1, cfg_load=0), history SHALL shift left with inp_bit entering bit 0; fill counter SHALL increment, saturating at PAT_LEN.
REQ-017 A match SHALL occur when the post-shift history equals the pattern and the post-shift fill equals PAT_LEN.
REQ-018 seq_seen SHALL be high for exactly the cycle after the clock edge that accepted the final pattern bit (latency 1); otherwise low.
REQ-019 Cycles with inp_valid=0 SHALL leave history, fill, and seq_seen low/unchanged, without breaking a partial match.
REQ-020 Overlap mode 1: after a match, fill SHALL remain PAT_LEN, so the next accepted bit can complete a new match.
REQ-021 Overlap mode 0: on a match, fill SHALL reset to 0, so the next match needs PAT_LEN fresh bits.
REQ-022 FSM states: FILL (fill<PAT_LEN) and ARMED (fill=PAT_LEN).
REQ-023 FSM transitions: FILL->ARMED when fill reaches PAT_LEN; ARMED->FILL on a mode-0 match or cfg_load; hist_full=1 only in ARMED.
REQ-024 cfg_load SHALL update the pattern and mode, flush history, zero fill, and enter FILL; a bit presented in the same cycle SHALL be discarded.
REQ-025 match_count SHALL increment by 1 per match and hold at all-ones on saturation (no wrap).
REQ-026 cnt_clear coincident with a match SHALL leave match_count at 0 (clear wins); seq_seen SHALL still pulse.
REQ-027 match_count SHALL be unaffected by cfg_load.

Reset
REQ-028 On reset assertion, the block SHALL immediately set seq_seen=0, match_count=0, hist_full=0, history=0, fill=0, state=FILL, pattern=RST_PATTERN, overlap=RST_OVERLAP.
REQ-029 Reset asserted mid-sequence SHALL discard any partial match; the first bit accepted after deassertion is bit 1 of a new match.

Structure
REQ-030 The FSM state encoding (FILL, ARMED) and PAT_LEN/CNT_W legal-range constants SHALL live in shared package seq_detect_pkg.
REQ-031 The saturating counter SHALL be a sub-module, sat_counter (parameter CNT_W; inputs inc, clr; clear priority).

Verification
REQ-032 Reset defaults (1011, overlap=1); stream 1,0,1,1 -> seq_seen pulses one cycle after 4th bit; match_count=1.
REQ-033 Overlap=1; stream 1,0,1,1,0,1,1 -> two seq_seen pulses (after bits 4 and 7); match_count=2.
REQ-034 Same stream with cfg_overlap=0 loaded first -> one pulse (after bit 4); match_count=1.
REQ-035 Stream 1,0,1 then 3 cycles inp_valid=0 then 1 -> pulse after final bit; reset asserted after bit 3 instead -> no pulse; hist_full=0.
REQ-036 CNT_W=2, 5 matches -> match_count 1,2,3,3,3; cnt_clear on 6th match cycle -> count 0 with seq_seen pulse.
REQ-037 cfg_load of 110 (PAT_LEN=3) with inp_bit=1, inp_valid=1 in the same cycle -> bit discarded; then 1,1,0 -> single pulse; match_count unchanged by the load.
